// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
//
// Handshake: a beat moves across a port on a rising edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge. in_ready comes only from the state register, so out_ready never reaches
// in_ready through logic. The skid entry takes the one extra beat that can
// arrive in the cycle after downstream stops accepting.
//
// flush squashes every held entry on the next edge. An accept in the same cycle
// is dropped. An emit in the same cycle still counts as delivered.
// stall_cnt counts consecutive cycles where out_valid is high and out_ready is
// low. It saturates at its maximum value.
module pipe_stage_hs #(
  parameter int                 DATA_W      = 64,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int                 STALL_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  // The current state is visible by hierarchical name (state) for checkers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   main_data;
  logic [CTRL_W-1:0]   main_ctrl;
  logic [DATA_W-1:0]   skid_data;
  logic [CTRL_W-1:0]   skid_ctrl;
  logic                accept;
  logic                emit;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_TWO);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // Next-state decode from the current occupancy, accept and emit; flush wins.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !emit)      state_next = ST_TWO;
          else if (emit && !accept) state_next = ST_EMPTY;
          else                      state_next = ST_ONE;
        end
        ST_TWO:   if (emit) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_next;
  end

  // Main and skid entries. The control field returns to the bubble code when an entry is vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
    end else if (flush) begin
      main_ctrl <= CTRL_BUBBLE;
      skid_ctrl <= CTRL_BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (accept) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (emit) begin
            main_ctrl <= CTRL_BUBBLE;
          end
        end
        ST_TWO: begin
          if (emit) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= CTRL_BUBBLE;
          end
        end
        default: begin
          main_ctrl <= CTRL_BUBBLE;
          skid_ctrl <= CTRL_BUBBLE;
        end
      endcase
    end
  end

  // Count consecutive stalled cycles, saturating. Emit or flush clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush || emit) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs. The reference model is a FIFO of up to two {ctrl,data} entries.
module tb_pipe_stage_hs;

  localparam int              DATA_W  = 64;
  localparam int              CTRL_W  = 8;
  localparam logic [7:0]      BUBBLE  = 8'h01;
  localparam int              STALL_W = 3;
  localparam int              STALL_SAT = (1 << STALL_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic [CTRL_W-1:0]  in_ctrl = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DATA_W-1:0]  out_data;
  logic [CTRL_W-1:0]  out_ctrl;
  logic               flush = 1'b0;
  logic [STALL_W-1:0] stall_cnt;

  pipe_stage_hs #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUBBLE), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard / model ----------------
  logic [CTRL_W+DATA_W-1:0] exp_q[$];   // held entries, oldest first
  int  exp_stall = 0;
  int  checks = 0;
  int  failures = 0;
  bit  accepted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output with the model's view of the stage.
  task automatic compare_outputs();
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0][DATA_W-1:0]);
      check("out_ctrl", 64'(out_ctrl), 64'(exp_q[0][CTRL_W+DATA_W-1:DATA_W]));
    end else begin
      check("out_ctrl_bubble", 64'(out_ctrl), 64'(BUBBLE));
    end
  endtask

  // One clock: check outputs, cross the edge, and update the model from the inputs seen at that edge.
  task automatic step();
    bit acc, emt, stalled;
    compare_outputs();
    acc     = in_valid && (exp_q.size() < 2);
    emt     = (exp_q.size() > 0) && out_ready;
    stalled = (exp_q.size() > 0) && !out_ready;
    @(posedge clk);
    accepted = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      exp_stall = 0;
    end else if (flush) begin
      exp_q.delete();
      exp_stall = 0;
    end else begin
      if (emt) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({in_ctrl, in_data});
        accepted = 1'b1;
      end
      if (emt) exp_stall = 0;
      else if (stalled && exp_stall < STALL_SAT) exp_stall++;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Offer one beat and hold it until it is taken, within a cycle budget.
  task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c, input int budget);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    accepted = 1'b0;
    while (!accepted && n < budget) begin
      step();
      n++;
    end
    check("send_timeout", 64'(accepted), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset: toggle inputs, which must be ignored.
    in_valid = 1'b1; in_data = 64'hDEAD; in_ctrl = 8'h55; out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_ctrl", 64'(out_ctrl), 64'(BUBBLE));
    check("rst_out_data", out_data, 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // First beat: one cycle of latency.
    out_ready = 1'b1;
    send(64'hA, 8'h80, 4);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_data", out_data, 64'hA);
    idle(2);

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i + 16);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      check("stream_accept", 64'(accepted), 64'd1);
    end
    in_valid = 1'b0;
    check("stream_last", out_data, 64'd8);
    idle(2);

    // Backpressure: 1 in main, 2 in skid, 3 held upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'd1; in_ctrl = 8'h11; step();
    in_data = 64'd2; in_ctrl = 8'h12; step();
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    in_data = 64'd3; in_ctrl = 8'h13;
    idle(4);
    check("stall_is_5", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1;
    step();
    check("bp_first_out", out_data, 64'd2);
    check("bp_stall_clear", 64'(stall_cnt), 64'd0);
    while (!accepted) step();
    in_valid = 1'b0;
    check("bp_third_out", out_data, 64'd3);
    idle(2);

    // Flush in TWO with a beat offered in the same cycle.
    out_ready = 1'b0;
    send(64'd1, 8'h21, 3);
    send(64'd2, 8'h22, 3);
    in_valid = 1'b1; in_data = 64'd9; in_ctrl = 8'h29; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'(BUBBLE));
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    idle(3);

    // Stall counter saturation.
    out_ready = 1'b0;
    send(64'h77, 8'h33, 3);
    idle(10);
    check("stall_sat", 64'(stall_cnt), 64'(STALL_SAT));
    out_ready = 1'b1;
    idle(2);

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    send(64'd5, 8'h44, 3);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ctrl", 64'(out_ctrl), 64'(BUBBLE));
    exp_q.delete();
    exp_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(64'hBEEF, 8'h66, 3);
    check("post_rst_data", out_data, 64'hBEEF);
    idle(1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = {$urandom, $urandom};
      in_ctrl   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 99) < 65);
      flush     = ($urandom_range(0, 99) < 5);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It is the generic successor to the fixed-field inter-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). Each stage instantiates it with its own data and control widths. Downstream backpressure stalls the pipeline without a combinational ready path, and hazard/branch logic squashes in-flight instructions.

## Interface
- DATA_W, 64, width of payload bus (PC, register addresses, immediate, etc.); ≥1
- CTRL_W, 8, width of control bus (RegWrite, MemtoReg, write, branch, ALUOp, ...); ≥1
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented when stage is empty, flushed or in reset (NOP encoding)
- STALL_W, 8, width of stall counter; ≥1

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  stage presents a valid instruction
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  payload to next stage
- out_ctrl  out  CTRL_W  control to next stage; CTRL_BUBBLE when out_valid=0
- flush  in  1  synchronous squash of all held entries
- stall_cnt  out  STALL_W  consecutive cycles with out_valid & !out_ready, saturating

## Operation
- Storage: main entry (main_data, main_ctrl), skid entry (skid_data, skid_ctrl), 2-bit state.
- States: EMPTY (no entries), ONE (main valid), TWO (main and skid valid).
- out_valid = (state != EMPTY). out_data = main_data. out_ctrl = main_ctrl.
- in_ready = (state != TWO). It is decoded from the state register only, so there is no combinational path from out_ready.
- accept = in_valid & in_ready. emit = out_valid & out_ready.
- EMPTY: accept -> ONE, main <= in.
- ONE: accept & emit -> ONE, main <= in. accept & !emit -> TWO, skid <= in. emit & !accept -> EMPTY, main_ctrl <= CTRL_BUBBLE. Neither -> hold.
- TWO: emit -> ONE, main <= skid, skid_ctrl <= CTRL_BUBBLE. !emit -> hold. No accept is possible because in_ready=0.
- Order is preserved: the skid entry is always younger than the main entry.
- flush has highest priority. Next state is EMPTY, and main_ctrl, skid_ctrl <= CTRL_BUBBLE. Data registers are unchanged (don't-care).
- A same-cycle accept under flush is dropped. A same-cycle emit under flush still counts as transferred downstream; downstream sees out_valid=1 that cycle.
- stall_cnt: when out_valid & !out_ready & !flush, increment, saturating at 2^STALL_W-1. On emit or flush, clear to 0. Otherwise hold.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - state=EMPTY, out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0.
  - Skid data is 0 and skid ctrl is CTRL_BUBBLE.
  - Input activity during reset is ignored.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: accept in cycle N -> out_valid=1 with that payload in cycle N+1.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Backpressure: one extra beat is absorbed after out_ready falls. in_ready drops in the cycle after the skid entry is filled and rises in the cycle after the skid entry drains.
- out_ctrl equals CTRL_BUBBLE in every cycle where out_valid=0.
- stall_cnt is registered: it reflects stall cycles up to and including the previous edge.

## Test plan
- Reset with CTRL_BUBBLE=8'h01 -> out_valid=0, in_ready=1, out_ctrl=8'h01, out_data=0, stall_cnt=0. Then remove reset, send data=64'hA with out_ready=1 -> next cycle out_valid=1, out_data=64'hA.
- Stream of 8 beats 1..8 with out_ready=1 constantly -> outputs 1..8 on consecutive cycles, in_ready never 0, stall_cnt stays 0.
- Send beats 1,2,3 with out_ready=0 from the cycle beat 1 lands:
  - 2 is held in skid, then in_ready=0, and 3 is held upstream.
  - After 5 stall cycles, stall_cnt=5.
  - Raise out_ready -> 1, 2, 3 emerge in order, and stall_cnt=0 after the first emit.
- State TWO (main=1, skid=2), assert flush for 1 cycle with in_valid=1, data=9 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1, and 9 is never emitted.
- STALL_W=3, hold a valid entry with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays 7.
- State ONE with entry 5, assert rst_n=0 asynchronously between edges -> out_valid=0 and out_ctrl=CTRL_BUBBLE immediately. After release, the stage accepts new data normally.
